dcim_sram_ctrl: RTL and testbench
=================================

DCIM_SRAM_CTRL -- requirements
Module: dcim_sram_ctrl

Interface
REQ-001 Parameter ADDR_W, default 6, SRAM word-address width.
REQ-002 Parameter DATA_W, default 32, SRAM word width.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on posedge clk.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-006 The block SHALL have port req_valid, input, 1 bit: burst request valid.
REQ-007 The block SHALL have port req_ready, output, 1 bit: controller can accept a request.
REQ-008 The block SHALL have port req_write, input, 1 bit: 1 = write burst, 0 = read burst.
REQ-009 The block SHALL have port req_addr, input, ADDR_W bits: burst start address.
REQ-010 The block SHALL have port req_len, input, ADDR_W bits: beats minus one (1..64 beats).
REQ-011 The block SHALL have port wdata_valid, input, 1 bit: write beat valid.
REQ-012 The block SHALL have port wdata_ready, output, 1 bit: write beat accepted this cycle.
REQ-013 The block SHALL have port wdata, input, DATA_W bits: write beat data.
REQ-014 The block SHALL have port rdata_valid, output, 1 bit: read beat valid (no backpressure).
REQ-015 The block SHALL have port rdata, output, DATA_W bits: read beat data.
REQ-016 The block SHALL have port rdata_last, output, 1 bit: final read beat of burst.
REQ-017 The block SHALL have port done, output, 1 bit: one-cycle pulse at burst completion.
REQ-018 The block SHALL have port sram_ce_n, output, 1 bit: SRAM chip enable, active low.
REQ-019 The block SHALL have port sram_we_n, output, 1 bit: SRAM write enable, active low (0 = write, 1 = read).
REQ-020 The block SHALL have port sram_addr, output, ADDR_W bits: SRAM address.
REQ-021 The block SHALL have port sram_wd, output, DATA_W bits: SRAM write data.
REQ-022 The block SHALL have port sram_rd, input, DATA_W bits: SRAM read data, updated by the SRAM on negedge clk.

Function
REQ-023 States SHALL be IDLE, RD, RD_DRAIN, WR and WR_LAST; all sram_* outputs SHALL be registered.
REQ-024 req_ready SHALL be 1 only in IDLE; a request is accepted at the posedge where req_valid && req_ready, latching addr, len and direction into a beat counter and address pointer.
REQ-025 Accept with req_write=0 -> RD; each RD cycle SHALL drive sram_ce_n=0, sram_we_n=1, sram_addr=pointer, one beat per cycle, no gaps.
REQ-026 A read beat issued in cycle k SHALL be captured from sram_rd at posedge k+1 and presented with rdata_valid=1 in cycle k+1 (latency 1).
REQ-027 After the last read beat is issued -> RD_DRAIN for 1 cycle: sram_ce_n=1, rdata_valid=1, rdata_last=1, done=1; then IDLE.
REQ-028 Accept with req_write=1 -> WR; wdata_ready SHALL be 1 in WR only, combinationally from state.
REQ-029 Each wdata_valid && wdata_ready posedge SHALL register sram_ce_n=0, sram_we_n=0, sram_addr=pointer, sram_wd=wdata for exactly one cycle; a cycle without a beat drives sram_ce_n=1 (gap).
REQ-030 After the last write beat is accepted -> WR_LAST for 1 cycle (SRAM commits on that cycle's closing posedge), done=1; then IDLE with sram_ce_n=1.
REQ-031 The pointer SHALL increment modulo 2^ADDR_W per beat (63 -> 0 wraps); req_len=63 gives 64 beats covering every address once.
REQ-032 sram_addr/sram_wd SHALL retain their last value while sram_ce_n=1; rdata SHALL hold until the next read beat.
REQ-033 req_valid while busy SHALL be ignored (not accepted); wdata_valid outside WR SHALL be ignored.
REQ-034 sram_ce_n=0 with sram_we_n=0 SHALL never coincide with a read beat; exactly one operation per burst.

Reset
REQ-035 rst=1 at a posedge SHALL force IDLE: sram_ce_n=1, sram_we_n=1, sram_addr=0, sram_wd=0, rdata=0, rdata_valid=0, rdata_last=0, done=0, req_ready=1 in the following cycle.
REQ-036 Reset mid-burst SHALL abandon the burst without done; beats already committed stay in SRAM; no further SRAM access is issued.

Verification
REQ-037 Write addr=5 len=0 data 0xA5A5_0001, then read addr=5 len=0 -> rdata=0xA5A5_0001 with rdata_valid and rdata_last in the same cycle, done pulsed per burst.
REQ-038 Write addr=62 len=3 data 1,2,3,4 -> mem[62]=1, mem[63]=2, mem[0]=3, mem[1]=4; read back same range -> 1,2,3,4 on consecutive cycles.
REQ-039 Write burst len=2 with wdata_valid low for 2 cycles between beats -> sram_ce_n=1 during the gaps, 3 writes total, addresses contiguous.
REQ-040 Full 64-beat write (data = address) then 64-beat read from addr 0 -> rdata k == k for all k, rdata_last only on beat 63.
REQ-041 rst asserted during beat 2 of a 4-beat write -> sram_ce_n=1 next cycle, no done, req_ready=1; beats 0-1 readable, beats 2-3 unchanged.
REQ-042 req_valid held high during a read burst -> second request accepted only in the first IDLE cycle after done.

Source files
------------

// File: rtl/dcim_sram_ctrl.sv
// Burst controller for a single-port synchronous SRAM holding compute-in-memory weights.
// Reads stream out back-to-back with one-cycle latency; writes are paced by wdata_valid.
module dcim_sram_ctrl #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [ADDR_W-1:0] req_len,
    input  logic              wdata_valid,
    output logic              wdata_ready,
    input  logic [DATA_W-1:0] wdata,
    output logic              rdata_valid,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_last,
    output logic              done,
    output logic              sram_ce_n,
    output logic              sram_we_n,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wd,
    input  logic [DATA_W-1:0] sram_rd
);

    typedef enum logic [2:0] {IDLE, RD, RD_DRAIN, WR, WR_LAST} state_t;

    localparam logic [ADDR_W-1:0] ONE = 1;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              ce_n_q, ce_n_d;
    logic              we_n_q, we_n_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wd_q, wd_d;
    logic [DATA_W-1:0] rdata_q;
    logic              rdata_valid_q;
    logic              rdata_last_q;

    // cnt_q holds the number of beats still to be issued after the one on the SRAM pins
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        ce_n_d  = 1'b1;
        we_n_d  = 1'b1;
        addr_d  = addr_q;
        wd_d    = wd_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    ptr_d = req_addr;
                    cnt_d = req_len;
                    if (req_write) begin
                        state_d = WR;
                    end else begin
                        state_d = RD;
                        ce_n_d  = 1'b0;
                        addr_d  = req_addr;
                        ptr_d   = req_addr + ONE;
                    end
                end
            end
            RD: begin
                if (cnt_q == '0) begin
                    state_d = RD_DRAIN;
                end else begin
                    ce_n_d = 1'b0;
                    addr_d = ptr_q;
                    ptr_d  = ptr_q + ONE;
                    cnt_d  = cnt_q - ONE;
                end
            end
            RD_DRAIN: state_d = IDLE;
            WR: begin
                if (wdata_valid) begin
                    ce_n_d = 1'b0;
                    we_n_d = 1'b0;
                    addr_d = ptr_q;
                    wd_d   = wdata;
                    ptr_d  = ptr_q + ONE;
                    if (cnt_q == '0) state_d = WR_LAST;
                    else             cnt_d   = cnt_q - ONE;
                end
            end
            WR_LAST: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            cnt_q         <= '0;
            ce_n_q        <= 1'b1;
            we_n_q        <= 1'b1;
            addr_q        <= '0;
            wd_q          <= '0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
            rdata_last_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            cnt_q         <= cnt_d;
            ce_n_q        <= ce_n_d;
            we_n_q        <= we_n_d;
            addr_q        <= addr_d;
            wd_q          <= wd_d;
            // SRAM drives sram_rd on the negedge inside the beat cycle
            rdata_valid_q <= !ce_n_q && we_n_q;
            rdata_last_q  <= (state_q == RD) && (cnt_q == '0);
            if (!ce_n_q && we_n_q) rdata_q <= sram_rd;
        end
    end

    assign req_ready   = (state_q == IDLE);
    assign wdata_ready = (state_q == WR);
    assign done        = (state_q == RD_DRAIN) || (state_q == WR_LAST);
    assign rdata_valid = rdata_valid_q;
    assign rdata       = rdata_q;
    assign rdata_last  = rdata_last_q;
    assign sram_ce_n   = ce_n_q;
    assign sram_we_n   = we_n_q;
    assign sram_addr   = addr_q;
    assign sram_wd     = wd_q;

endmodule

// File: tb/tb_dcim_sram_ctrl.sv
// Directed bench for dcim_sram_ctrl: burst table plus hand-written reset and back-to-back
// request sequences, against a behavioural SRAM that reads on negedge and writes on posedge.
module tb_dcim_sram_ctrl;
    localparam int AW = 6;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0, req_ready, req_write = 1'b0;
    logic [AW-1:0] req_addr = '0, req_len = '0;
    logic          wdata_valid = 1'b0, wdata_ready;
    logic [DW-1:0] wdata = '0;
    logic          rdata_valid, rdata_last, done;
    logic [DW-1:0] rdata;
    logic          sram_ce_n, sram_we_n;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wd, sram_rd;

    always #5 clk = ~clk;

    dcim_sram_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_len(req_len),
        .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
        .rdata_valid(rdata_valid), .rdata(rdata), .rdata_last(rdata_last), .done(done),
        .sram_ce_n(sram_ce_n), .sram_we_n(sram_we_n), .sram_addr(sram_addr),
        .sram_wd(sram_wd), .sram_rd(sram_rd)
    );

    logic [DW-1:0] mem [0:63];
    always @(posedge clk) if (!sram_ce_n && !sram_we_n) mem[sram_addr] <= sram_wd;
    always @(negedge clk) if (!sram_ce_n && sram_we_n) sram_rd <= mem[sram_addr];

    // Monitor: append-only logs sampled mid-cycle
    int            cyc = 0;
    int            done_cnt = 0, done_cyc = 0, clash = 0;
    logic [DW-1:0] rd_q[$];
    bit            rdl_q[$];
    int            rdc_q[$];
    logic [AW-1:0] wa_q[$];
    logic [DW-1:0] wd_q[$];
    int            acc_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
        if (rdata_valid) begin
            rd_q.push_back(rdata);
            rdl_q.push_back(rdata_last);
            rdc_q.push_back(cyc);
        end
        if (!sram_ce_n && !sram_we_n) begin
            wa_q.push_back(sram_addr);
            wd_q.push_back(sram_wd);
            if (rdata_valid) clash = clash + 1;
        end
        if (req_valid && req_ready) acc_cyc.push_back(cyc);
    end

    int tests = 0;
    int failed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct packed {
        logic                wr;
        logic [AW-1:0]       addr;
        logic [AW-1:0]       len;
        logic [1:0]          gap;
        logic [3:0][DW-1:0]  d;
    } vec_t;

    function automatic vec_t mk(input logic wr, input logic [AW-1:0] a, input logic [AW-1:0] l,
                                input logic [1:0] g, input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                                input logic [DW-1:0] d2, input logic [DW-1:0] d3);
        vec_t v;
        v.wr = wr; v.addr = a; v.len = l; v.gap = g;
        v.d = {d3, d2, d1, d0};
        return v;
    endfunction

    task automatic send_req(input logic wr, input logic [AW-1:0] a, input logic [AW-1:0] l);
        int n = 0;
        while (!req_ready && n < 50) begin
            tick();
            n++;
        end
        chk("req_ready_before_req", {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1; req_write = wr; req_addr = a; req_len = l;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input int base);
        int n = 0;
        while (done_cnt == base && n < 200) begin
            tick();
            n++;
        end
        tick();
        tick();
        chk("done_pulses", done_cnt - base, 32'd1);
    endtask

    task automatic run_write(input logic [AW-1:0] a, input logic [AW-1:0] l, input int gap,
                             input logic [3:0][DW-1:0] d, input bit ident);
        int db = done_cnt;
        int wb = wa_q.size();
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        send_req(1'b1, a, l);
        chk("wdata_ready_in_wr", {31'b0, wdata_ready}, 32'd1);
        for (int i = 0; i <= int'(l); i++) begin
            if (i > 0) begin
                for (int g = 0; g < gap; g++) begin
                    wdata_valid = 1'b0;
                    tick();
                    chk("gap_ce_n", {31'b0, sram_ce_n}, 32'd1);
                end
            end
            ea = a + i[AW-1:0];
            wdata_valid = 1'b1;
            wdata = ident ? {{(DW-AW){1'b0}}, ea} : d[i[1:0]];
            tick();
        end
        wdata_valid = 1'b0;
        wait_done(db);
        chk("wdata_ready_after", {31'b0, wdata_ready}, 32'd0);
        chk("wr_count", wa_q.size() - wb, int'(l) + 1);
        for (int i = 0; i <= int'(l); i++) begin
            if (wb + i < wa_q.size()) begin
                ea = a + i[AW-1:0];
                ed = ident ? {{(DW-AW){1'b0}}, ea} : d[i[1:0]];
                chk("wr_addr", {26'b0, wa_q[wb+i]}, {26'b0, ea});
                chk("wr_data", wd_q[wb+i], ed);
            end
        end
        $display("[TB] write addr=%0d len=%0d gap=%0d beats=%0d", a, l, gap, wa_q.size() - wb);
    endtask

    task automatic run_read(input logic [AW-1:0] a, input logic [AW-1:0] l,
                            input logic [3:0][DW-1:0] d, input bit ident);
        int db = done_cnt;
        int rb = rd_q.size();
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        ed = '0;
        send_req(1'b0, a, l);
        chk("rd_first_ce_n", {31'b0, sram_ce_n}, 32'd0);
        chk("rd_first_we_n", {31'b0, sram_we_n}, 32'd1);
        chk("rd_first_addr", {26'b0, sram_addr}, {26'b0, a});
        wait_done(db);
        chk("rd_count", rd_q.size() - rb, int'(l) + 1);
        for (int i = 0; i <= int'(l); i++) begin
            if (rb + i < rd_q.size()) begin
                ea = a + i[AW-1:0];
                ed = ident ? {{(DW-AW){1'b0}}, ea} : d[i[1:0]];
                chk("rd_data", rd_q[rb+i], ed);
                chk("rd_last", {31'b0, rdl_q[rb+i]}, {31'b0, (i == int'(l))});
                chk("rd_no_gap", rdc_q[rb+i] - rdc_q[rb], i);
            end
        end
        chk("rdata_hold", rdata, ed);
        $display("[TB] read  addr=%0d len=%0d beats=%0d", a, l, rd_q.size() - rb);
    endtask

    vec_t vecs[7];

    initial begin
        int db, wb, ab, n;
        logic [3:0][DW-1:0] nod;
        nod = '0;

        vecs[0] = mk(1'b1, 6'd5,  6'd0, 2'd0, 32'hA5A5_0001, 32'h0, 32'h0, 32'h0);
        vecs[1] = mk(1'b0, 6'd5,  6'd0, 2'd0, 32'hA5A5_0001, 32'h0, 32'h0, 32'h0);
        vecs[2] = mk(1'b1, 6'd62, 6'd3, 2'd0, 32'd1, 32'd2, 32'd3, 32'd4);
        vecs[3] = mk(1'b0, 6'd62, 6'd3, 2'd0, 32'd1, 32'd2, 32'd3, 32'd4);
        vecs[4] = mk(1'b1, 6'd10, 6'd2, 2'd2, 32'd11, 32'd22, 32'd33, 32'h0);
        vecs[5] = mk(1'b0, 6'd10, 6'd2, 2'd0, 32'd11, 32'd22, 32'd33, 32'h0);
        vecs[6] = mk(1'b0, 6'd63, 6'd1, 2'd0, 32'd2, 32'd3, 32'h0, 32'h0);

        repeat (3) tick();
        chk("rst_ce_n", {31'b0, sram_ce_n}, 32'd1);
        chk("rst_we_n", {31'b0, sram_we_n}, 32'd1);
        chk("rst_addr", {26'b0, sram_addr}, 32'd0);
        chk("rst_wd", sram_wd, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_rvalid", {31'b0, rdata_valid}, 32'd0);
        chk("rst_rlast", {31'b0, rdata_last}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_wdata_ready", {31'b0, wdata_ready}, 32'd0);
        rst = 1'b0;
        tick();

        for (int k = 0; k < 7; k++) begin
            if (vecs[k].wr) run_write(vecs[k].addr, vecs[k].len, int'(vecs[k].gap), vecs[k].d, 1'b0);
            else            run_read(vecs[k].addr, vecs[k].len, vecs[k].d, 1'b0);
        end

        // Full-array write with data = address, then full read
        run_write(6'd0, 6'd63, 0, nod, 1'b1);
        run_read(6'd0, 6'd63, nod, 1'b1);

        // Reset lands on the posedge that would accept beat 2 of a 4-beat write
        db = done_cnt;
        wb = wa_q.size();
        send_req(1'b1, 6'd20, 6'd3);
        wdata_valid = 1'b1; wdata = 32'hB000_0000; tick();
        wdata = 32'hB000_0001; tick();
        wdata = 32'hB000_0002; rst = 1'b1; tick();
        rst = 1'b0; wdata_valid = 1'b0;
        chk("midrst_ce_n", {31'b0, sram_ce_n}, 32'd1);
        chk("midrst_addr", {26'b0, sram_addr}, 32'd0);
        chk("midrst_req_ready", {31'b0, req_ready}, 32'd1);
        wdata_valid = 1'b1; wdata = 32'hDEAD_BEEF; tick();
        chk("idle_wdata_ignored", {31'b0, sram_ce_n}, 32'd1);
        wdata_valid = 1'b0;
        repeat (3) tick();
        chk("midrst_no_done", done_cnt - db, 32'd0);
        chk("midrst_wr_count", wa_q.size() - wb, 32'd2);
        $display("[TB] write addr=20 len=3 reset after %0d beats", wa_q.size() - wb);
        run_read(6'd20, 6'd3, {32'd23, 32'd22, 32'hB000_0001, 32'hB000_0000}, 1'b0);

        // req_valid held through a read burst
        db = done_cnt;
        ab = acc_cyc.size();
        n = 0;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 6'd0; req_len = 6'd3;
        while (acc_cyc.size() - ab < 2 && n < 40) begin
            tick();
            n++;
        end
        req_valid = 1'b0;
        chk("held_accepts", acc_cyc.size() - ab, 32'd2);
        chk("held_done_before_2nd", done_cnt - db, 32'd1);
        if (acc_cyc.size() >= ab + 2)
            chk("held_accept_after_done", acc_cyc[ab+1] - done_cyc, 32'd1);
        wait_done(db + 1);
        $display("[TB] read  addr=0 len=3 twice with req_valid held, accepts=%0d", acc_cyc.size() - ab);

        chk("no_write_read_clash", clash, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
